// File: rtl/tpu_apb_pkg.sv
// rtl/tpu_apb_pkg.sv - register offsets, bit indices and APB phase enum for tpu_apb_regs
package tpu_apb_pkg;

    // Word indices (paddr[4:2]) of the register map
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_A_BASE  = 3'd2;
    localparam logic [2:0] REG_B_BASE  = 3'd3;
    localparam logic [2:0] REG_C_BASE  = 3'd4;
    localparam logic [2:0] REG_SCRATCH = 3'd5;
    localparam logic [2:0] REG_VERSION = 3'd6;
    localparam logic [2:0] REG_CYCLES  = 3'd7;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/tpu_apb_regs.sv
// rtl/tpu_apb_regs.sv - APB register block controlling a TPU array run
module tpu_apb_regs
    import tpu_apb_pkg::*;
#(
    parameter logic [31:0] VERSION = 32'h0001_0404,
    parameter int          CNT_W   = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_paddr,
    input  logic        i_psel,
    input  logic        i_penable,
    input  logic        i_pwrite,
    input  logic [31:0] i_pwdata,
    output logic [31:0] o_prdata,
    output logic        o_pready,
    output logic        o_pslverr,
    output logic        o_tpu_start,
    input  logic        i_tpu_done,
    output logic [31:0] o_a_base,
    output logic [31:0] o_b_base,
    output logic [31:0] o_c_base,
    output logic        o_irq
);

    apb_state_e       state_q, state_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             err_q, err_d;
    logic             irq_en_q, irq_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_q, start_d;
    logic [31:0]      a_base_q, a_base_d;
    logic [31:0]      b_base_q, b_base_d;
    logic [31:0]      c_base_q, c_base_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]  idx;
    logic        invalid;
    logic        err;
    logic [31:0] rdata;
    logic        wr_en;
    logic        start_commit;
    logic        unused_paddr_lsbs;

    assign idx               = i_paddr[4:2];
    assign invalid           = |i_paddr[31:5];
    assign unused_paddr_lsbs = ^i_paddr[1:0];

    // state_d is the bus phase of the current cycle; state_q remembers the last one
    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_SETUP) begin
            if (i_psel && i_penable)       state_d = ST_ACCESS;
            else if (i_psel && !i_penable) state_d = ST_SETUP;
        end else if (i_psel && !i_penable) begin
            state_d = ST_SETUP;
        end
    end

    always_comb begin
        rdata = '0;
        err   = invalid;
        case (idx)
            REG_CTRL: begin
                rdata[CTRL_IRQ_EN] = irq_en_q;
                if (i_pwrite && i_pwdata[CTRL_START] && busy_q) err = 1'b1;
            end
            REG_STATUS: begin
                rdata[STAT_BUSY] = busy_q;
                rdata[STAT_DONE] = done_q;
            end
            REG_A_BASE: begin
                rdata = a_base_q;
                if (i_pwrite && busy_q) err = 1'b1;
            end
            REG_B_BASE: begin
                rdata = b_base_q;
                if (i_pwrite && busy_q) err = 1'b1;
            end
            REG_C_BASE: begin
                rdata = c_base_q;
                if (i_pwrite && busy_q) err = 1'b1;
            end
            REG_SCRATCH: rdata = scratch_q;
            REG_VERSION: begin
                rdata = VERSION;
                if (i_pwrite) err = 1'b1;
            end
            default: begin
                rdata[CNT_W-1:0] = cnt_q;
                if (i_pwrite) err = 1'b1;
            end
        endcase
    end

    assign wr_en        = (state_d == ST_ACCESS) && i_pwrite && !err_q;
    assign start_commit = wr_en && (idx == REG_CTRL) && i_pwdata[CTRL_START];

    always_comb begin
        prdata_d  = prdata_q;
        err_d     = err_q;
        irq_en_d  = irq_en_q;
        a_base_d  = a_base_q;
        b_base_d  = b_base_q;
        c_base_d  = c_base_q;
        scratch_d = scratch_q;
        start_d   = start_commit;
        busy_d    = busy_q;
        done_d    = done_q;
        cnt_d     = cnt_q;

        if (state_d == ST_SETUP) begin
            prdata_d = err ? 32'd0 : rdata;
            err_d    = err;
        end

        if (wr_en) begin
            case (idx)
                REG_CTRL:    irq_en_d  = i_pwdata[CTRL_IRQ_EN];
                REG_STATUS:  if (i_pwdata[STAT_DONE]) done_d = 1'b0;
                REG_A_BASE:  a_base_d  = i_pwdata;
                REG_B_BASE:  b_base_d  = i_pwdata;
                REG_C_BASE:  c_base_d  = i_pwdata;
                REG_SCRATCH: scratch_d = i_pwdata;
                default:     ;
            endcase
        end

        // Completion is applied after the W1C so that a coincident done pulse wins
        if (i_tpu_done && (busy_q || start_commit)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end

        if (start_commit) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            prdata_q  <= '0;
            err_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            c_base_q  <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            err_q     <= err_d;
            irq_en_q  <= irq_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            start_q   <= start_d;
            a_base_q  <= a_base_d;
            b_base_q  <= b_base_d;
            c_base_q  <= c_base_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_prdata    = prdata_q;
    assign o_pready    = (state_d == ST_ACCESS);
    assign o_pslverr   = (state_d == ST_ACCESS) && err_q;
    assign o_tpu_start = start_q;
    assign o_a_base    = a_base_q;
    assign o_b_base    = b_base_q;
    assign o_c_base    = c_base_q;
    assign o_irq       = done_q && irq_en_q;

endmodule
